// File: rtl/matrix_ascii_formatter_if.sv
// Handshake bundle between the matrix formatter, its element storage and the UART transmitter.
// The master modport is the formatter side; the slave modport is the storage/transmitter/requester side.
interface matrix_ascii_formatter_if;
    localparam int unsigned DIM_W  = 3;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;

    logic              start;
    logic [DIM_W-1:0]  dim_m;
    logic [DIM_W-1:0]  dim_n;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, dim_m, dim_n, rd_data, tx_ready,
        output rd_addr, rd_en, tx_data, tx_valid, busy, done
    );

    modport slave (
        output start, dim_m, dim_n, rd_data, tx_ready,
        input  rd_addr, rd_en, tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/matrix_ascii_formatter.sv
// Streams an m x n matrix of unsigned bytes as ASCII text ("m n" header, space-separated
// rows ending CR LF) to a byte-wide transmitter, fetching elements from storage in row-major order.
module matrix_ascii_formatter (
    input  logic                    clk,
    input  logic                    rst_n,
    matrix_ascii_formatter_if.master bus
);
    localparam int unsigned DIM_W  = 3;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] SPACE   = 8'h20;
    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;

    typedef enum logic [2:0] {IDLE, HDR, FETCH, WAIT_RD, CONV, EMIT, SEP, FIN} state_t;

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  m_q, m_d, n_q, n_d, row_q, row_d, col_q, col_d;
    logic [2:0]        hdr_idx_q, hdr_idx_d;
    logic [1:0]        dig_idx_q, dig_idx_d;
    logic              lf_q, lf_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [1:0]        hun_q, hun_d;
    logic [3:0]        ten_q, ten_d, one_q, one_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_en_q, rd_en_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic              free_c;
    logic [7:0]        hdr_byte_c, dig_byte_c, rem_c;
    logic [1:0]        hun_c;
    logic [3:0]        ten_c, one_c;

    // Decimal split by compare/subtract: hundreds first, then the largest tens multiple not above the rest.
    always_comb begin
        hun_c = 2'd0;
        rem_c = val_q;
        if (val_q >= 8'd200) begin
            hun_c = 2'd2;
            rem_c = val_q - 8'd200;
        end else if (val_q >= 8'd100) begin
            hun_c = 2'd1;
            rem_c = val_q - 8'd100;
        end
        ten_c = 4'd0;
        for (int t = 1; t < 10; t++) begin
            if (rem_c >= 8'(t * 10)) ten_c = 4'(t);
        end
        one_c = 4'(rem_c - 8'(ten_c) * 8'd10);
    end

    always_comb begin
        case (hdr_idx_q)
            3'd0:    hdr_byte_c = ASCII_0 + 8'(m_q);
            3'd1:    hdr_byte_c = SPACE;
            3'd2:    hdr_byte_c = ASCII_0 + 8'(n_q);
            3'd3:    hdr_byte_c = CR;
            default: hdr_byte_c = LF;
        endcase
        case (dig_idx_q)
            2'd2:    dig_byte_c = ASCII_0 + 8'(hun_q);
            2'd1:    dig_byte_c = ASCII_0 + 8'(ten_q);
            default: dig_byte_c = ASCII_0 + 8'(one_q);
        endcase
    end

    // Next-state logic; the output byte register may be reloaded whenever it is empty or being taken.
    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        n_d        = n_q;
        row_d      = row_q;
        col_d      = col_q;
        hdr_idx_d  = hdr_idx_q;
        dig_idx_d  = dig_idx_q;
        lf_d       = lf_q;
        val_d      = val_q;
        hun_d      = hun_q;
        ten_d      = ten_q;
        one_d      = one_q;
        rd_addr_d  = rd_addr_q;
        rd_en_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        free_c     = !tx_valid_q || bus.tx_ready;
        tx_valid_d = tx_valid_q && !bus.tx_ready;
        tx_data_d  = tx_data_q;

        case (state_q)
            IDLE: if (bus.start) begin
                m_d       = bus.dim_m;
                n_d       = bus.dim_n;
                row_d     = '0;
                col_d     = '0;
                hdr_idx_d = 3'd0;
                lf_d      = 1'b0;
                busy_d    = 1'b1;
                state_d   = HDR;
            end
            HDR: if (free_c) begin
                tx_data_d  = hdr_byte_c;
                tx_valid_d = 1'b1;
                if (hdr_idx_q == 3'd4) state_d = (m_q == '0 || n_q == '0) ? FIN : FETCH;
                else                   hdr_idx_d = hdr_idx_q + 3'd1;
            end
            FETCH:   state_d = WAIT_RD;
            WAIT_RD: begin
                val_d   = bus.rd_data;
                state_d = CONV;
            end
            CONV: begin
                hun_d     = hun_c;
                ten_d     = ten_c;
                one_d     = one_c;
                dig_idx_d = (hun_c != 2'd0) ? 2'd2 : ((ten_c != 4'd0) ? 2'd1 : 2'd0);
                state_d   = EMIT;
            end
            EMIT: if (free_c) begin
                tx_data_d  = dig_byte_c;
                tx_valid_d = 1'b1;
                if (dig_idx_q == 2'd0) state_d = SEP;
                else                   dig_idx_d = dig_idx_q - 2'd1;
            end
            SEP: if (free_c) begin
                tx_valid_d = 1'b1;
                if (4'(col_q) + 4'd1 < 4'(n_q)) begin
                    tx_data_d = SPACE;
                    col_d     = col_q + 3'd1;
                    state_d   = FETCH;
                end else if (!lf_q) begin
                    tx_data_d = CR;
                    lf_d      = 1'b1;
                end else begin
                    tx_data_d = LF;
                    lf_d      = 1'b0;
                    if (4'(row_q) + 4'd1 < 4'(m_q)) begin
                        row_d   = row_q + 3'd1;
                        col_d   = '0;
                        state_d = FETCH;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN: if (free_c) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Read strobe and address are registered so they line up with the FETCH cycle itself.
        if (state_d == FETCH) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ADDR_W'(row_d) * ADDR_W'(n_d) + ADDR_W'(col_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            m_q        <= '0;
            n_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            hdr_idx_q  <= '0;
            dig_idx_q  <= '0;
            lf_q       <= 1'b0;
            val_q      <= '0;
            hun_q      <= '0;
            ten_q      <= '0;
            one_q      <= '0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            n_q        <= n_d;
            row_q      <= row_d;
            col_q      <= col_d;
            hdr_idx_q  <= hdr_idx_d;
            dig_idx_q  <= dig_idx_d;
            lf_q       <= lf_d;
            val_q      <= val_d;
            hun_q      <= hun_d;
            ten_q      <= ten_d;
            one_q      <= one_d;
            rd_addr_q  <= rd_addr_d;
            rd_en_q    <= rd_en_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rd_addr  = rd_addr_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_matrix_ascii_formatter.sv
// Randomized bench for matrix_ascii_formatter: storage and transmitter models, a text-format
// reference built from the matrix contents, and a parser that reads the text back.
module tb_matrix_ascii_formatter;
    logic clk;
    logic rst_n;
    matrix_ascii_formatter_if bus();

    matrix_ascii_formatter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [64];
    logic [7:0] rx_q [$];
    int         rd_q [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         ready_mode = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         last_acc = 0;
    int         stab_err = 0;
    logic       busy_at_done;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data;
    logic [7:0] pend;
    logic       pend_v = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transmitter and storage models, acting just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        case (ready_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = ~bus.tx_ready;
            default: bus.tx_ready = 1'($urandom_range(0, 1));
        endcase
        bus.rd_data = pend_v ? pend : 8'($urandom);
        pend_v = 1'b0;
        if (rst_n) begin
            if (stall_prev && (bus.tx_valid !== 1'b1 || bus.tx_data !== stall_data)) stab_err++;
            stall_prev = bus.tx_valid && !bus.tx_ready;
            stall_data = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) begin
                rx_q.push_back(bus.tx_data);
                last_acc = cyc;
            end
            if (bus.rd_en) begin
                rd_q.push_back(int'(bus.rd_addr));
                pend   = mem[bus.rd_addr];
                pend_v = 1'b1;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = bus.busy;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    function automatic void push_str(ref logic [7:0] q [$], input string s);
        for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
    endfunction

    task automatic fill_mem(input int kind);
        logic [7:0] corner [8];
        corner = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199, 8'd200, 8'd255};
        for (int i = 0; i < 64; i++) begin
            if (kind == 1)                         mem[i] = 8'hFF;
            else if ($urandom_range(0, 1) == 0)    mem[i] = corner[$urandom_range(0, 7)];
            else                                   mem[i] = 8'($urandom);
        end
    endtask

    task automatic run_xfer(input int m, input int n, input int mode, input bit interfere);
        logic [7:0] exp_q [$];
        int         toks [$];
        int         acc;
        bit         in_num;
        int         e0;
        exp_q = {};
        push_str(exp_q, $sformatf("%0d %0d", m, n));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        for (int r = 0; r < m && n > 0; r++) begin
            for (int c = 0; c < n; c++) begin
                push_str(exp_q, $sformatf("%0d", mem[r * n + c]));
                if (c < n - 1) exp_q.push_back(8'h20);
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end

        rx_q.delete();
        rd_q.delete();
        done_cnt   = 0;
        stab_err   = 0;
        ready_mode = mode;
        @(posedge clk); #2;
        bus.dim_m = 3'(m);
        bus.dim_n = 3'(n);
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        bus.dim_m = 3'($urandom);
        bus.dim_n = 3'($urandom);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        for (int k = 0; k < 4000 && done_cnt == 0; k++) begin
            bus.start = (interfere && k == 7) ? 1'b1 : 1'b0;
            @(posedge clk); #2;
        end
        bus.start = 1'b0;
        check("done_seen", 32'(done_cnt), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        check("done_once", 32'(done_cnt), 32'd1);
        check("done_after_last_byte", 32'(done_cyc), 32'(last_acc + 1));
        check("busy_low_at_done", 32'(busy_at_done), 32'd0);
        check("stall_stable", 32'(stab_err), 32'd0);

        check("byte_count", 32'(rx_q.size()), 32'(exp_q.size()));
        e0 = n_err;
        for (int i = 0; i < rx_q.size() && i < exp_q.size() && n_err == e0; i++)
            check($sformatf("byte[%0d]", i), 32'(rx_q[i]), 32'(exp_q[i]));

        check("read_count", 32'(rd_q.size()), 32'(m * n));
        e0 = n_err;
        for (int i = 0; i < rd_q.size() && n_err == e0; i++)
            check($sformatf("read_addr[%0d]", i), 32'(rd_q[i]), 32'(i));

        // Read the text back the way the downstream parser would.
        acc = 0;
        in_num = 1'b0;
        foreach (rx_q[i]) begin
            if (rx_q[i] >= 8'h30 && rx_q[i] <= 8'h39) begin
                acc = acc * 10 + int'(rx_q[i] - 8'h30);
                in_num = 1'b1;
            end else if (in_num) begin
                toks.push_back(acc);
                acc = 0;
                in_num = 1'b0;
            end
        end
        check("parse_tokens", 32'(toks.size()), 32'(2 + m * n));
        if (toks.size() == 2 + m * n) begin
            check("parse_dim_m", 32'(toks[0]), 32'(m));
            check("parse_dim_n", 32'(toks[1]), 32'(n));
            e0 = n_err;
            for (int i = 0; i < m * n && n_err == e0; i++)
                check($sformatf("parse_elem[%0d]", i), 32'(toks[2 + i]), 32'(mem[i]));
        end
    endtask

    initial begin
        int m, n;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.dim_m = '0;
        bus.dim_n = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_rd_en", 32'(bus.rd_en), 32'd0);
        check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 2x2 with the receiver always ready
        mem[0] = 8'd5; mem[1] = 8'd10; mem[2] = 8'd100; mem[3] = 8'd255;
        run_xfer(2, 2, 0, 1'b0);

        // 1x3 with the receiver toggling ready every cycle
        mem[0] = 8'd0; mem[1] = 8'd9; mem[2] = 8'd200;
        run_xfer(1, 3, 1, 1'b0);

        // Empty matrix: header only, no reads
        run_xfer(0, 3, 0, 1'b0);
        run_xfer(4, 0, 2, 1'b0);

        // Largest matrix, three-digit values everywhere
        fill_mem(1);
        run_xfer(7, 7, 0, 1'b0);

        // Random shapes, values and backpressure, with a stray start mid-transfer
        for (int t = 0; t < 8; t++) begin
            fill_mem(0);
            m = $urandom_range(1, 7);
            n = $urandom_range(1, 7);
            run_xfer(m, n, 2, 1'b1);
        end

        // Abort mid-row: everything quiet immediately and after release until a new start
        fill_mem(0);
        ready_mode = 0;
        rx_q.delete();
        @(posedge clk); #2;
        bus.dim_m = 3'd3;
        bus.dim_n = 3'd3;
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        for (int k = 0; k < 200 && rx_q.size() < 9; k++) begin
            @(posedge clk); #2;
        end
        check("abort_reached_row", 32'(rx_q.size() >= 9), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_rd_en", 32'(bus.rd_en), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rx_q.delete();
        rd_q.delete();
        done_cnt = 0;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        check("post_abort_bytes", 32'(rx_q.size()), 32'd0);
        check("post_abort_reads", 32'(rd_q.size()), 32'd0);
        check("post_abort_done", 32'(done_cnt), 32'd0);
        check("post_abort_busy", 32'(bus.busy), 32'd0);
        run_xfer(3, 2, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
